// File: rtl/matmul_pkg.sv
// Shared types and helpers for the AXI-Stream matrix-multiply core.
package matmul_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int MAX_DIM_DEF = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      COMPUTE = 3'd2,
      OUTPUT  = 3'd3,
      DONE    = 3'd4
   } state_e;

   // Row-major linear index of element (row, col) in a matrix with ncols columns.
   function automatic int unsigned rm_idx(input int unsigned row,
                                          input int unsigned col,
                                          input int unsigned ncols);
      return row * ncols + col;
   endfunction

endpackage

// File: rtl/axis_matmul_core_if.sv
// AXI-Stream bundle (valid/ready/data/last) with master and slave views.
interface axis_matmul_core_if
   import matmul_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) ();
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic              tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/matmul_mac.sv
// Multiply-accumulate unit: clear/enable controlled accumulator of ACC_W bits.
// The result port reflects the accumulator value being written this cycle,
// reduced to DATA_W bits: wrapped by default, saturated when MATMUL_SAT_EN
// is defined.
module matmul_mac #(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 66
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] res_o
);
   logic [ACC_W-1:0] prod_s;
   logic [ACC_W-1:0] base_s;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W-1:0] acc_q;

   // Next accumulator: product added to zero (clear) or to the running sum.
   always_comb begin
      prod_s = ACC_W'(a_i) * ACC_W'(b_i);
      if (clr_i) begin
         base_s = {ACC_W{1'b0}};
      end else begin
         base_s = acc_q;
      end
      if (en_i) begin
         acc_d = base_s + prod_s;
      end else begin
         acc_d = base_s;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= {ACC_W{1'b0}};
      end else begin
         acc_q <= acc_d;
      end
   end

   // Output stage: reduce the accumulator to the stream width.
   always_comb begin
`ifdef MATMUL_SAT_EN
      if (|acc_d[ACC_W-1:DATA_W]) begin
         res_o = {DATA_W{1'b1}};
      end else begin
         res_o = acc_d[DATA_W-1:0];
      end
`else
      res_o = acc_d[DATA_W-1:0];
`endif
   end

endmodule

// File: rtl/axis_matmul_core.sv
// Matrix-multiply engine: loads A (MxK) and B (KxN) from two AXI-Stream
// slaves, computes C = A*B with a single MAC and streams C row-major.
// Optional build macro: MATMUL_SAT_EN (saturate C instead of wrapping).
module axis_matmul_core
   import matmul_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MAX_DIM = MAX_DIM_DEF,
   parameter int DIM_W   = $clog2(MAX_DIM + 1),
   parameter int ACC_W   = 2 * DATA_W + $clog2(MAX_DIM)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [DIM_W-1:0]   cfg_m,
   input  logic [DIM_W-1:0]   cfg_k,
   input  logic [DIM_W-1:0]   cfg_n,
   output logic               busy,
   output logic               done,
   output logic               err,
   axis_matmul_core_if.slave  s_axis_a,
   axis_matmul_core_if.slave  s_axis_b,
   axis_matmul_core_if.master m_axis_c
);
   localparam int DEPTH = MAX_DIM * MAX_DIM;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] a_mem [DEPTH];
   logic [DATA_W-1:0] b_mem [DEPTH];

   state_e            state_q, state_d;
   logic [DIM_W-1:0]  m_q, m_d, k_q, k_d, n_q, n_d;
   logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, p_q, p_d;
   logic [CW-1:0]     tot_a_q, tot_a_d, tot_b_q, tot_b_d;
   logic [CW-1:0]     a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
   logic              a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
   logic              c_vld_q, c_vld_d, c_last_q, c_last_d;
   logic [DATA_W-1:0] c_data_q, c_data_d;
   logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic              cfg_ok_s, a_acc_s, b_acc_s;
   logic              mac_en_s, mac_clr_s;
   logic [AW-1:0]     a_addr_s, b_addr_s;
   logic [DATA_W-1:0] mac_res_s;

   assign cfg_ok_s = (cfg_m != DIM_W'(0)) && (cfg_m <= DIM_W'(MAX_DIM)) &&
                     (cfg_k != DIM_W'(0)) && (cfg_k <= DIM_W'(MAX_DIM)) &&
                     (cfg_n != DIM_W'(0)) && (cfg_n <= DIM_W'(MAX_DIM));
   assign a_acc_s  = s_axis_a.tvalid && a_rdy_q;
   assign b_acc_s  = s_axis_b.tvalid && b_rdy_q;
   assign a_addr_s = AW'(rm_idx(32'(i_q), 32'(p_q), 32'(k_q)));
   assign b_addr_s = AW'(rm_idx(32'(p_q), 32'(j_q), 32'(n_q)));

   assign s_axis_a.tready = a_rdy_q;
   assign s_axis_b.tready = b_rdy_q;
   assign m_axis_c.tvalid = c_vld_q;
   assign m_axis_c.tdata  = c_data_q;
   assign m_axis_c.tlast  = c_last_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign err             = err_q;

   matmul_mac #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (mac_clr_s),
      .en_i  (mac_en_s),
      .a_i   (a_mem[a_addr_s]),
      .b_i   (b_mem[b_addr_s]),
      .res_o (mac_res_s)
   );

   // Operand buffers: accepted beats land at the current load count.
   always_ff @(posedge clk) begin
      if (a_acc_s) begin
         a_mem[AW'(a_cnt_q)] <= s_axis_a.tdata;
      end
      if (b_acc_s) begin
         b_mem[AW'(b_cnt_q)] <= s_axis_b.tdata;
      end
   end

   // Next-state and output logic for the load/compute/output sequence.
   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      k_d       = k_q;
      n_d       = n_q;
      i_d       = i_q;
      j_d       = j_q;
      p_d       = p_q;
      tot_a_d   = tot_a_q;
      tot_b_d   = tot_b_q;
      a_cnt_d   = a_cnt_q;
      b_cnt_d   = b_cnt_q;
      c_vld_d   = c_vld_q;
      c_last_d  = c_last_q;
      c_data_d  = c_data_q;
      done_d    = done_q;
      err_d     = err_q;
      mac_en_s  = 1'b0;
      mac_clr_s = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start && cfg_ok_s) begin
               m_d     = cfg_m;
               k_d     = cfg_k;
               n_d     = cfg_n;
               tot_a_d = CW'(cfg_m) * CW'(cfg_k);
               tot_b_d = CW'(cfg_k) * CW'(cfg_n);
               a_cnt_d = {CW{1'b0}};
               b_cnt_d = {CW{1'b0}};
               i_d     = {DIM_W{1'b0}};
               j_d     = {DIM_W{1'b0}};
               p_d     = {DIM_W{1'b0}};
               done_d  = 1'b0;
               err_d   = 1'b0;
               state_d = LOAD;
            end else if (start) begin
               done_d  = 1'b0;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = state_q;
            end
         end
         LOAD: begin
            // Counting follows the configuration; tlast is only cross-checked.
            a_cnt_d = a_cnt_q + CW'(a_acc_s);
            b_cnt_d = b_cnt_q + CW'(b_acc_s);
            err_d   = err_q
                    | (a_acc_s & (s_axis_a.tlast ^ (a_cnt_q == tot_a_q - CW'(1))))
                    | (b_acc_s & (s_axis_b.tlast ^ (b_cnt_q == tot_b_q - CW'(1))));
            if ((a_cnt_d == tot_a_q) && (b_cnt_d == tot_b_q)) begin
               state_d = COMPUTE;
            end else begin
               state_d = LOAD;
            end
         end
         COMPUTE: begin
            mac_en_s  = 1'b1;
            mac_clr_s = (p_q == {DIM_W{1'b0}});
            if (p_q == k_q - DIM_W'(1)) begin
               p_d      = {DIM_W{1'b0}};
               c_vld_d  = 1'b1;
               c_data_d = mac_res_s;
               c_last_d = (i_q == m_q - DIM_W'(1)) && (j_q == n_q - DIM_W'(1));
               state_d  = OUTPUT;
            end else begin
               p_d = p_q + DIM_W'(1);
            end
         end
         OUTPUT: begin
            if (m_axis_c.tready) begin
               c_vld_d = 1'b0;
               if (c_last_q) begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end else if (j_q == n_q - DIM_W'(1)) begin
                  j_d     = {DIM_W{1'b0}};
                  i_d     = i_q + DIM_W'(1);
                  state_d = COMPUTE;
               end else begin
                  j_d     = j_q + DIM_W'(1);
                  state_d = COMPUTE;
               end
            end else begin
               state_d = OUTPUT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      a_rdy_d = (state_d == LOAD) && (a_cnt_d < tot_a_d);
      b_rdy_d = (state_d == LOAD) && (b_cnt_d < tot_b_d);
      busy_d  = (state_d == LOAD) || (state_d == COMPUTE) || (state_d == OUTPUT);
   end

   // State, counters and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         m_q      <= {DIM_W{1'b0}};
         k_q      <= {DIM_W{1'b0}};
         n_q      <= {DIM_W{1'b0}};
         i_q      <= {DIM_W{1'b0}};
         j_q      <= {DIM_W{1'b0}};
         p_q      <= {DIM_W{1'b0}};
         tot_a_q  <= {CW{1'b0}};
         tot_b_q  <= {CW{1'b0}};
         a_cnt_q  <= {CW{1'b0}};
         b_cnt_q  <= {CW{1'b0}};
         a_rdy_q  <= 1'b0;
         b_rdy_q  <= 1'b0;
         c_vld_q  <= 1'b0;
         c_last_q <= 1'b0;
         c_data_q <= {DATA_W{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         k_q      <= k_d;
         n_q      <= n_d;
         i_q      <= i_d;
         j_q      <= j_d;
         p_q      <= p_d;
         tot_a_q  <= tot_a_d;
         tot_b_q  <= tot_b_d;
         a_cnt_q  <= a_cnt_d;
         b_cnt_q  <= b_cnt_d;
         a_rdy_q  <= a_rdy_d;
         b_rdy_q  <= b_rdy_d;
         c_vld_q  <= c_vld_d;
         c_last_q <= c_last_d;
         c_data_q <= c_data_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: doc/axis_matmul_core.md
Name: axis_matmul_core

Overview:
Parametrised matrix-multiply engine; successor to the fixed-size compute wrapper inside axi_matrix_accelerator. Buffers A (MxK) and B (KxN) from two AXI-Stream slaves and computes C = A*B with one MAC. Streams C row-major on an AXI-Stream master, honouring backpressure. Dimensions are runtime-configurable up to MAX_DIM; control comes from the AXI-Lite register block (start, cfg_*, done, err).

Parameters:
DATA_W, 32, width of stream data and operands (unsigned)
MAX_DIM, 4, maximum value of M, K, N; buffer depth is MAX_DIM*MAX_DIM per matrix
DIM_W, $clog2(MAX_DIM+1), width of cfg_m/k/n
ACC_W, 2*DATA_W+$clog2(MAX_DIM), internal accumulator width

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle start pulse
cfg_m  in  DIM_W  rows of A/C
cfg_k  in  DIM_W  cols of A / rows of B
cfg_n  in  DIM_W  cols of B/C
busy  out  1  high in LOAD/COMPUTE/OUTPUT
done  out  1  sticky completion flag
err  out  1  sticky error flag (bad cfg or tlast mismatch)
s_axis_a_tvalid/tready/tdata/tlast  in/out/in/in  1/1/DATA_W/1  A stream, row-major
s_axis_b_tvalid/tready/tdata/tlast  in/out/in/in  1/1/DATA_W/1  B stream, row-major
m_axis_c_tvalid/tready/tdata/tlast  out/in/out/out  1/1/DATA_W/1  C stream, row-major

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, err, all tready, m_axis_c_tvalid/tlast = 0; tdata = 0; counters cleared. Buffer contents don't-care.
- States: IDLE, LOAD, COMPUTE, OUTPUT, DONE.
- IDLE/DONE + start:
  - Any cfg value 0 or >MAX_DIM -> err=1, done=0, go/stay IDLE.
  - Else latch cfg, clear done and err, go to LOAD next cycle.
- start in LOAD/COMPUTE/OUTPUT: ignored; cfg changes there are ignored (latched copy used).
- LOAD:
  - s_axis_a_tready=1 while a_cnt < M*K; s_axis_b_tready=1 while b_cnt < K*N. A and B load concurrently and independently.
  - A beat is accepted only on tvalid&&tready; it is written at index cnt, then cnt increments.
  - tlast must equal (cnt==total-1) on every accepted beat; a mismatch sets err (sticky). Counting is by cfg, never by tlast.
  - When both counts are complete -> COMPUTE; both treadys drop the same cycle the last beat is accepted.
- COMPUTE: for element (i,j), acc += A[i][p]*B[p][j], p=0..K-1, one MAC per cycle. Acc clears at p=0. After K cycles, register result to m_axis_c_tdata and go to OUTPUT.
  - Element latency: K cycles compute + >=1 cycle output.
- OUTPUT:
  - m_axis_c_tvalid=1; tdata/tlast held stable until tready.
  - tlast=1 only for (M-1,N-1).
  - On handshake: advance j, wrapping to the next i; go to COMPUTE, or to DONE after the last element. tvalid drops the cycle after the handshake.
- Arithmetic: unsigned; tdata = acc[DATA_W-1:0] (wrap modulo 2^DATA_W) unless MATMUL_SAT_EN.
- DONE: done=1 until the next accepted start or reset; busy=0.
- Reset mid-operation: immediate abort to IDLE; no partial C output is required afterwards. A subsequent start runs cleanly from empty counters.
- Stream data presented outside LOAD is not consumed (tready=0).

Optional Feature:
MATMUL_SAT_EN:
- Defined: if acc > 2^DATA_W-1, tdata = all-ones (saturate).
- Undefined: truncate to the low DATA_W bits.
- All other behaviour is identical.

Decomposition:
- Package matmul_pkg: state enum typedef (IDLE, LOAD, COMPUTE, OUTPUT, DONE), DATA_W/MAX_DIM defaults, a function computing the row-major index (row, col, ncols).
- One sub-module: matmul_mac (multiply-accumulate with clear and enable, ACC_W result, optional saturation output stage).
- Buffers are inferred arrays in the top.

Test Plan:
1. M=N=K=2, A=[0,1,2,3], B=[0,1,2,3], tready=1 -> C=[2,3,6,11]; tlast only on the 4th beat; done=1; busy=0; err=0.
2. Same data with random tvalid on A/B and random C tready -> identical C values and order; tdata/tlast stable while tvalid && !tready.
3. M=3, K=1, N=2, A=[1,2,3], B=[4,5] -> C=[4,5,8,10,12,15]; 6 beats; tlast on 6th.
4. cfg_k=0 or cfg_m=MAX_DIM+1, then start -> err=1, done=0, state IDLE, all tready=0; a valid start afterwards clears err and runs.
5. rst_n low for 2 cycles during COMPUTE, then a fresh start with test 1 data -> outputs zero during reset; the rerun gives C=[2,3,6,11].
6. A tlast asserted on beat 2 of 4 -> err=1, load still takes 4 beats, C correct. Start while done=1 -> done clears and a second run completes. DATA_W=8, A=B=[255] 1x1x1: with MATMUL_SAT_EN -> C=255; without -> C=1.
